fare_collector: RTL and testbench
=================================

Name: fare_collector

Overview:
- Upstream stage of the ticket-issuing FSM.
- Accepts coin/note insertion events and accumulates the inserted amount.
- Latches the passenger's destination and ticket count when the passenger confirms, then presents a stable Input_money/dest_sel/ticket_count bundle with a one-cycle transaction strobe.
- Handles passenger cancel and an inactivity timeout by returning the collected money, and waits for the ticket stage's Time_up before accepting a new passenger.

Parameters:
- MAX_MONEY, 200, largest accumulated amount accepted; must be ≤ 255.
- TIMEOUT_CYC, 1000, idle cycles in COLLECT before an automatic refund; must be ≥ 2.
- VAL0, 5, value of coin_type 2'b00.
- VAL1, 10, value of coin_type 2'b01.
- VAL2, 20, value of coin_type 2'b10.
- VAL3, 50, value of coin_type 2'b11.

Ports:
- clk  in  1  system clock; all logic on posedge.
- arstn  in  1  reset; synchronous, active-low.
- coin_valid  in  1  one-cycle insertion event.
- coin_type  in  2  denomination code, valid with coin_valid.
- confirm  in  1  passenger confirm button, level-sampled.
- cancel  in  1  passenger cancel button, level-sampled.
- dest_sel_in  in  2  destination keypad value.
- ticket_count_in  in  2  ticket quantity keypad value.
- done  in  1  Time_up from the ticket stage timer.
- transaction  out  1  one-cycle start strobe to the ticket stage.
- Input_money  out  8  accumulated amount, held stable until done.
- dest_sel  out  2  latched destination.
- ticket_count  out  2  latched ticket quantity.
- coin_reject  out  1  one-cycle pulse; coin returned, not counted.
- refund_valid  out  1  one-cycle pulse; cancel_amount valid.
- cancel_amount  out  8  amount returned on cancel or timeout.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (arstn=0 at posedge):
  - State goes to IDLE.
  - Accumulator, latches and timeout counter clear to 0.
  - All outputs are 0 the cycle after reset.
  - Reset asserted in any state, including WAIT_DONE, aborts without a refund pulse.
- All outputs are registered.
- Coin value is the selected VALn. The add is done 9 bits wide: sum = total + value.
  - sum > MAX_MONEY: coin_reject pulses; total unchanged.
  - sum = MAX_MONEY exactly: the coin is accepted.
- IDLE:
  - total = 0.
  - confirm and cancel are ignored.
  - An accepted coin adds its value and moves to COLLECT.
  - An over-limit first coin is rejected and the state stays IDLE.
- COLLECT, evaluated in priority order each cycle:
  1. cancel → REFUND.
  2. confirm with total ≠ 0 → latch dest_sel_in and ticket_count_in → ISSUE.
  3. coin_valid → add or reject per the sum rule.
  4. Otherwise the timeout counter increments.
- COLLECT simultaneous events:
  - A coin arriving in the same cycle as cancel or confirm is rejected (coin_reject=1), so it is not lost silently.
- COLLECT timeout counter:
  - Clears to 0 on each accepted coin.
  - Reaching TIMEOUT_CYC-1 → REFUND.
- ISSUE:
  - transaction=1 for exactly one cycle → WAIT_DONE.
  - Input_money, dest_sel and ticket_count are already valid in this cycle.
- WAIT_DONE:
  - Input_money, dest_sel and ticket_count are held constant.
  - Coins are rejected.
  - confirm and cancel are ignored.
  - transaction never re-fires.
  - done=1 → IDLE, and total/latches clear next cycle.
  - There is no timeout in this state.
- REFUND:
  - refund_valid=1 and cancel_amount=total for one cycle → IDLE.
  - A coin in this cycle is rejected.
  - cancel_amount returns to 0 when refund_valid is low.
- Input_money tracks total live in COLLECT and is frozen from ISSUE through WAIT_DONE.
- No arithmetic wraps: the 8-bit total can never exceed MAX_MONEY.

Test Plan:
1. Reset, then coins 10,20 (2 cycles apart), dest_sel_in=2, ticket_count_in=1, confirm → transaction single pulse with Input_money=30, dest_sel=2, ticket_count=1; values held through 20 cycles; done → IDLE, Input_money=0, busy=0.
2. Coins 50,50,50,50 then 5 (MAX_MONEY=200) → first four accepted, total=200; fifth coin gives coin_reject=1, total stays 200.
3. Coins 10,5 then cancel → refund_valid one cycle, cancel_amount=15, transaction never asserted; next cycle IDLE.
4. Coin 20, no further input for TIMEOUT_CYC cycles → refund_valid with cancel_amount=20; a coin at cycle TIMEOUT_CYC-5 restarts the count.
5. Same-cycle confirm+coin(50) with total=10 → coin_reject=1, transaction with Input_money=10; same-cycle cancel+confirm → refund only.
6. arstn low for one cycle during WAIT_DONE with Input_money=30 → all outputs 0, no refund_valid; confirm while in IDLE with total=0 → no transaction.

Source files
------------

// File: rtl/fare_collector.sv
// Fare collector: accumulates coins, latches the passenger's selection and hands a
// stable money/destination/quantity bundle to the ticket stage, or refunds on cancel/timeout.
module fare_collector #(
    parameter int unsigned MAX_MONEY   = 200,
    parameter int unsigned TIMEOUT_CYC = 1000,
    parameter int unsigned VAL0        = 5,
    parameter int unsigned VAL1        = 10,
    parameter int unsigned VAL2        = 20,
    parameter int unsigned VAL3        = 50
) (
    input  logic       clk,
    input  logic       arstn,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    input  logic       confirm,
    input  logic       cancel,
    input  logic [1:0] dest_sel_in,
    input  logic [1:0] ticket_count_in,
    input  logic       done,
    output logic       transaction,
    output logic [7:0] Input_money,
    output logic [1:0] dest_sel,
    output logic [1:0] ticket_count,
    output logic       coin_reject,
    output logic       refund_valid,
    output logic [7:0] cancel_amount,
    output logic       busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_ISSUE,
        S_WAIT_DONE,
        S_REFUND
    } state_t;

    state_t           r_state;
    logic [7:0]       r_total;
    logic [1:0]       r_dest;
    logic [1:0]       r_tix;
    logic [CNT_W-1:0] r_cnt;
    logic             r_transaction;
    logic             r_coin_reject;
    logic             r_refund_valid;
    logic [7:0]       r_cancel_amount;
    logic             r_busy;

    state_t           w_state_nxt;
    logic [7:0]       w_total_nxt;
    logic [1:0]       w_dest_nxt;
    logic [1:0]       w_tix_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_reject;
    logic [7:0]       w_refund_amt;
    logic [7:0]       w_value;
    logic [8:0]       w_sum;
    logic             w_fits;

    always_comb begin
        case (coin_type)
            2'b00:   w_value = 8'(VAL0);
            2'b01:   w_value = 8'(VAL1);
            2'b10:   w_value = 8'(VAL2);
            default: w_value = 8'(VAL3);
        endcase
    end

    // Nine-bit sum so an over-limit coin is detected rather than wrapped.
    assign w_sum  = {1'b0, r_total} + {1'b0, w_value};
    assign w_fits = (w_sum <= 9'(MAX_MONEY));

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        w_state_nxt  = r_state;
        w_total_nxt  = r_total;
        w_dest_nxt   = r_dest;
        w_tix_nxt    = r_tix;
        w_cnt_nxt    = r_cnt;
        w_reject     = 1'b0;
        w_refund_amt = 8'd0;

        case (r_state)
            S_IDLE: begin
                w_total_nxt = 8'd0;
                w_cnt_nxt   = '0;
                if (coin_valid) begin
                    if (w_fits) begin
                        w_total_nxt = w_sum[7:0];
                        w_state_nxt = S_COLLECT;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            S_COLLECT: begin
                // A coin colliding with cancel/confirm is bounced back, never swallowed.
                if (cancel) begin
                    w_state_nxt  = S_REFUND;
                    w_reject     = coin_valid;
                    w_refund_amt = r_total;
                    w_cnt_nxt    = '0;
                end else if (confirm && r_total != 8'd0) begin
                    w_state_nxt = S_ISSUE;
                    w_dest_nxt  = dest_sel_in;
                    w_tix_nxt   = ticket_count_in;
                    w_reject    = coin_valid;
                    w_cnt_nxt   = '0;
                end else if (coin_valid) begin
                    if (w_fits) begin
                        w_total_nxt = w_sum[7:0];
                        w_cnt_nxt   = '0;
                    end else begin
                        w_reject = 1'b1;
                    end
                end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    w_state_nxt  = S_REFUND;
                    w_refund_amt = r_total;
                    w_cnt_nxt    = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_ISSUE: begin
                w_reject    = coin_valid;
                w_state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                w_reject = coin_valid;
                if (done) begin
                    w_state_nxt = S_IDLE;
                    w_total_nxt = 8'd0;
                    w_dest_nxt  = 2'd0;
                    w_tix_nxt   = 2'd0;
                end
            end
            S_REFUND: begin
                w_reject    = coin_valid;
                w_total_nxt = 8'd0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_total_nxt = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!arstn) begin
            r_state         <= S_IDLE;
            r_total         <= 8'd0;
            r_dest          <= 2'd0;
            r_tix           <= 2'd0;
            r_cnt           <= '0;
            r_transaction   <= 1'b0;
            r_coin_reject   <= 1'b0;
            r_refund_valid  <= 1'b0;
            r_cancel_amount <= 8'd0;
            r_busy          <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_total         <= w_total_nxt;
            r_dest          <= w_dest_nxt;
            r_tix           <= w_tix_nxt;
            r_cnt           <= w_cnt_nxt;
            r_transaction   <= (w_state_nxt == S_ISSUE);
            r_coin_reject   <= w_reject;
            r_refund_valid  <= (w_state_nxt == S_REFUND);
            r_cancel_amount <= w_refund_amt;
            r_busy          <= (w_state_nxt != S_IDLE);
        end
    end

    assign transaction   = r_transaction;
    assign Input_money   = r_total;
    assign dest_sel      = r_dest;
    assign ticket_count  = r_tix;
    assign coin_reject   = r_coin_reject;
    assign refund_valid  = r_refund_valid;
    assign cancel_amount = r_cancel_amount;
    assign busy          = r_busy;

endmodule

// File: tb/tb_fare_collector.sv
// Directed bench for fare_collector: inputs change on the falling edge, outputs are
// sampled on the falling edge after each rising edge, against hand-computed values.
module tb_fare_collector;

    logic       clk = 1'b0;
    logic       arstn;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       confirm;
    logic       cancel;
    logic [1:0] dest_sel_in;
    logic [1:0] ticket_count_in;
    logic       done;
    logic       transaction;
    logic [7:0] Input_money;
    logic [1:0] dest_sel;
    logic [1:0] ticket_count;
    logic       coin_reject;
    logic       refund_valid;
    logic [7:0] cancel_amount;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    fare_collector dut (
        .clk            (clk),
        .arstn          (arstn),
        .coin_valid     (coin_valid),
        .coin_type      (coin_type),
        .confirm        (confirm),
        .cancel         (cancel),
        .dest_sel_in    (dest_sel_in),
        .ticket_count_in(ticket_count_in),
        .done           (done),
        .transaction    (transaction),
        .Input_money    (Input_money),
        .dest_sel       (dest_sel),
        .ticket_count   (ticket_count),
        .coin_reject    (coin_reject),
        .refund_valid   (refund_valid),
        .cancel_amount  (cancel_amount),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        coin_valid      = 1'b0;
        coin_type       = 2'b00;
        confirm         = 1'b0;
        cancel          = 1'b0;
        done            = 1'b0;
    endtask

    task automatic coin(input logic [1:0] t);
        coin_valid = 1'b1;
        coin_type  = t;
        step();
        coin_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        int acc;
        acc = int'(transaction) + int'(Input_money) + int'(dest_sel) + int'(ticket_count)
            + int'(coin_reject) + int'(refund_valid) + int'(cancel_amount) + int'(busy);
        check(tag, acc, 0);
    endtask

    // Steps until refund_valid is seen; returns the number of steps (or -1 on timeout).
    task automatic wait_refund(input int limit, output int steps, output int amount);
        steps  = -1;
        amount = -1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (refund_valid) begin
                steps  = i;
                amount = int'(cancel_amount);
                break;
            end
        end
    endtask

    initial begin
        int bad;
        int steps;
        int amount;

        idle_inputs();
        dest_sel_in     = 2'd0;
        ticket_count_in = 2'd0;
        arstn           = 1'b0;
        step();
        step();
        arstn = 1'b1;
        check_all_zero("reset_outputs");

        // 1: 10 + 20, confirm, hold through WAIT_DONE, then done
        coin(2'b01);
        check("t1_first_coin", Input_money, 10);
        check("t1_busy", busy, 1);
        step();
        coin(2'b10);
        check("t1_total30", Input_money, 30);
        step();
        dest_sel_in     = 2'd2;
        ticket_count_in = 2'd1;
        confirm         = 1'b1;
        step();
        confirm = 1'b0;
        check("t1_txn", transaction, 1);
        check("t1_money", Input_money, 30);
        check("t1_dest", dest_sel, 2);
        check("t1_tix", ticket_count, 1);
        dest_sel_in     = 2'd3;
        ticket_count_in = 2'd3;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            confirm = (i == 3);
            cancel  = (i == 7);
            step();
            if (transaction || Input_money != 8'd30 || dest_sel != 2'd2 ||
                ticket_count != 2'd1 || refund_valid || !busy)
                bad++;
        end
        idle_inputs();
        check("t1_hold", bad, 0);
        coin(2'b11);
        check("t1_wait_reject", coin_reject, 1);
        check("t1_wait_money", Input_money, 30);
        done = 1'b1;
        step();
        done = 1'b0;
        check("t1_done_money", Input_money, 0);
        check("t1_done_busy", busy, 0);
        check("t1_done_dest", dest_sel, 0);

        // 2: 50 x4 reaches MAX exactly; 5 more is rejected
        for (int i = 0; i < 4; i++) coin(2'b11);
        check("t2_total200", Input_money, 200);
        check("t2_no_reject", coin_reject, 0);
        coin(2'b00);
        check("t2_reject", coin_reject, 1);
        check("t2_total_held", Input_money, 200);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        check("t2_refund200", cancel_amount, 200);
        step();
        check("t2_idle", busy, 0);

        // 3: 10 + 5 then cancel
        coin(2'b01);
        coin(2'b00);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        check("t3_refund_valid", refund_valid, 1);
        check("t3_amount", cancel_amount, 15);
        check("t3_no_txn", transaction, 0);
        step();
        check("t3_refund_drop", refund_valid, 0);
        check("t3_amount_zero", cancel_amount, 0);
        check("t3_idle", busy, 0);

        // 4: timeout after TIMEOUT_CYC idle cycles; a coin at TIMEOUT_CYC-5 restarts it
        coin(2'b10);
        wait_refund(1100, steps, amount);
        check("t4_timeout_cycles", steps, 1000);
        check("t4_timeout_amount", amount, 20);
        step();
        coin(2'b10);
        bad = 0;
        for (int i = 0; i < 994; i++) begin
            step();
            if (refund_valid) bad++;
        end
        check("t4_no_early_refund", bad, 0);
        coin(2'b00);
        wait_refund(1100, steps, amount);
        check("t4_restart_cycles", steps, 1000);
        check("t4_restart_amount", amount, 25);
        step();

        // 5: confirm+coin collision, then cancel+confirm collision
        coin(2'b01);
        confirm         = 1'b1;
        coin_valid      = 1'b1;
        coin_type       = 2'b11;
        dest_sel_in     = 2'd1;
        ticket_count_in = 2'd3;
        step();
        idle_inputs();
        check("t5_reject", coin_reject, 1);
        check("t5_txn", transaction, 1);
        check("t5_money", Input_money, 10);
        check("t5_tix", ticket_count, 3);
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        coin(2'b00);
        cancel  = 1'b1;
        confirm = 1'b1;
        step();
        idle_inputs();
        check("t5_both_refund", refund_valid, 1);
        check("t5_both_amount", cancel_amount, 5);
        check("t5_both_no_txn", transaction, 0);
        step();
        check("t5_after_txn", transaction, 0);
        check("t5_after_busy", busy, 0);

        // 6: reset during WAIT_DONE, then confirm in IDLE
        coin(2'b01);
        coin(2'b10);
        confirm = 1'b1;
        step();
        confirm = 1'b0;
        step();
        check("t6_wait_money", Input_money, 30);
        arstn = 1'b0;
        step();
        arstn = 1'b1;
        check_all_zero("t6_reset_abort");
        confirm = 1'b1;
        step();
        check("t6_idle_confirm_txn", transaction, 0);
        check("t6_idle_confirm_busy", busy, 0);
        step();
        confirm = 1'b0;
        check("t6_idle_confirm_txn2", transaction, 0);
        check("t6_no_refund", refund_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
